// File: rtl/turbo_pkg.sv
// Shared turbo-loop definitions: default widths and block geometry, the
// FILL/DRAIN state encoding and the symmetric saturation used across stages.
package turbo_pkg;

  localparam int DEF_DATA_W   = 10;
  localparam int DEF_EXT_W    = 7;
  localparam int DEF_BLK_LEN  = 7;
  localparam int DEF_STEP     = 3;
  localparam int DEF_INV_STEP = 5;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Clamp to +/-(2^(w-1)-1) so the most-negative code never appears and
  // negation downstream cannot overflow.
  function automatic logic signed [31:0] sat_sym(input logic signed [31:0] x,
                                                 input int w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (x > lim)
      return lim;
    else if (x < -lim)
      return -lim;
    else
      return x;
  endfunction

endpackage

// File: rtl/perm_addr_gen.sv
// Modular read-address accumulator: addr += STEP or INV_STEP, wrapped into
// [0, BLK_LEN) with a single conditional subtract.
module perm_addr_gen #(
  parameter int BLK_LEN  = 7,
  parameter int STEP     = 3,
  parameter int INV_STEP = 5,
  parameter int AW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  input  logic          mode,
  output logic [AW-1:0] addr
);

  localparam logic [AW:0] LEN    = (AW + 1)'(BLK_LEN);
  localparam logic [AW:0] STEP_F = (AW + 1)'(STEP);
  localparam logic [AW:0] STEP_R = (AW + 1)'(INV_STEP);

  logic [AW:0]   sum;
  logic [AW-1:0] nxt;

  // Both operands are below BLK_LEN, so one subtract always lands in range.
  always_comb begin
    sum = {1'b0, addr} + (mode ? STEP_R : STEP_F);
    nxt = (sum >= LEN) ? AW'(sum - LEN) : AW'(sum);
  end

  always_ff @(posedge clk) begin
    if (rst || clear)
      addr <= '0;
    else if (advance)
      addr <= nxt;
  end

endmodule

// File: rtl/ext_interleaver.sv
// Extrinsic stage after the SISO: buffers sat(llr - sys - apr) for one block,
// then replays it in interleaved or de-interleaved order as the next a-priori.
module ext_interleaver #(
  parameter int DATA_W   = turbo_pkg::DEF_DATA_W,
  parameter int EXT_W    = turbo_pkg::DEF_EXT_W,
  parameter int BLK_LEN  = turbo_pkg::DEF_BLK_LEN,
  parameter int STEP     = turbo_pkg::DEF_STEP,
  parameter int INV_STEP = turbo_pkg::DEF_INV_STEP
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mode_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] llr_i,
  input  logic signed [EXT_W-1:0]  sys_i,
  input  logic signed [EXT_W-1:0]  apr_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [EXT_W-1:0]  ext_o,
  output logic                     blk_done_o
);

  import turbo_pkg::*;

  localparam int AW = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
  localparam int DW = DATA_W + 2;
  localparam logic [AW-1:0] LAST = AW'(BLK_LEN - 1);

  state_t                   state;
  logic [AW-1:0]            wr_cnt;
  logic [AW-1:0]            rd_cnt;
  logic [AW-1:0]            rd_addr;
  logic                     mode_q;
  logic                     done_q;
  logic signed [EXT_W-1:0]  mem [BLK_LEN];

  logic signed [DW-1:0]     diff_p0;
  logic signed [EXT_W-1:0]  ext_p0;
  logic                     in_acc;
  logic                     out_acc;
  logic                     last_out;

  // Stage 0: extrinsic value formed combinationally from the SISO outputs
  always_comb begin
    diff_p0 = DW'(llr_i) - DW'(sys_i) - DW'(apr_i);
    ext_p0  = EXT_W'(sat_sym(32'(diff_p0), EXT_W));
  end

  assign in_ready_o  = (state == FILL);
  assign out_valid_o = (state == DRAIN);
  assign in_acc      = in_valid_i & in_ready_o;
  assign out_acc     = out_valid_o & out_ready_i;
  assign last_out    = out_acc && (rd_cnt == LAST);
  assign ext_o       = mem[rd_addr];
  assign blk_done_o  = done_q;

  // Stage 1: block buffer and FILL/DRAIN control
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= FILL;
      wr_cnt <= '0;
      rd_cnt <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < BLK_LEN; i++)
        mem[i] <= '0;
    end else begin
      done_q <= last_out;
      case (state)
        FILL: begin
          if (in_acc) begin
            mem[wr_cnt] <= ext_p0;
            if (wr_cnt == '0)
              mode_q <= mode_i;
            if (wr_cnt == LAST) begin
              wr_cnt <= '0;
              state  <= DRAIN;
            end else begin
              wr_cnt <= wr_cnt + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_acc) begin
            if (rd_cnt == LAST) begin
              rd_cnt <= '0;
              state  <= FILL;
            end else begin
              rd_cnt <= rd_cnt + AW'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  perm_addr_gen #(
    .BLK_LEN  (BLK_LEN),
    .STEP     (STEP),
    .INV_STEP (INV_STEP),
    .AW       (AW)
  ) u_addr (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (last_out),
    .advance (out_acc),
    .mode    (mode_q),
    .addr    (rd_addr)
  );

endmodule

// File: tb/tb_ext_interleaver.sv
// Directed bench for ext_interleaver: a reference model pushes the expected
// permuted extrinsic stream into a queue that is popped on each output accept.
module tb_ext_interleaver;

  localparam int DATA_W   = 10;
  localparam int EXT_W    = 7;
  localparam int BLK_LEN  = 7;
  localparam int STEP     = 3;
  localparam int INV_STEP = 5;
  localparam int LIM      = (1 << (EXT_W - 1)) - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     mode;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] llr;
  logic signed [EXT_W-1:0]  sys;
  logic signed [EXT_W-1:0]  apr;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [EXT_W-1:0]  ext;
  logic                     blk_done;

  int checks = 0;
  int errors = 0;

  logic signed [EXT_W-1:0] exp_q [$];
  int blk_llr [BLK_LEN];
  int blk_sys [BLK_LEN];
  int blk_apr [BLK_LEN];

  ext_interleaver #(
    .DATA_W   (DATA_W),
    .EXT_W    (EXT_W),
    .BLK_LEN  (BLK_LEN),
    .STEP     (STEP),
    .INV_STEP (INV_STEP)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mode_i      (mode),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .llr_i       (llr),
    .sys_i       (sys),
    .apr_i       (apr),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .ext_o       (ext),
    .blk_done_o  (blk_done)
  );

  always #5 clk = ~clk;

  function automatic logic signed [EXT_W-1:0] ref_ext(int l, int s, int a);
    int d;
    d = l - s - a;
    if (d > LIM) d = LIM;
    if (d < -LIM) d = -LIM;
    return EXT_W'(d);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drives one block; the first beat may share the current negedge.
  task automatic send_block(input logic m, input bit flip, input bit no_wait);
    logic signed [EXT_W-1:0] vals [BLK_LEN];
    int s;
    for (int k = 0; k < BLK_LEN; k++) begin
      if (!(k == 0 && no_wait)) begin
        @(negedge clk);
        check("blk_done_idle", blk_done, 0);
      end
      in_valid = 1'b1;
      llr  = DATA_W'(blk_llr[k]);
      sys  = EXT_W'(blk_sys[k]);
      apr  = EXT_W'(blk_apr[k]);
      mode = (flip && k > 0) ? ~m : m;
      check("in_ready_fill", in_ready, 1);
      check("out_valid_fill", out_valid, 0);
      vals[k] = ref_ext(blk_llr[k], blk_sys[k], blk_apr[k]);
    end
    s = m ? INV_STEP : STEP;
    for (int k = 0; k < BLK_LEN; k++)
      exp_q.push_back(vals[(k * s) % BLK_LEN]);
  endtask

  // pat: 0 = always ready, 1 = ready on every third cycle (1,0,0,1,...).
  task automatic drain(input int pat, input bit junk_in, input int stop_after);
    int cyc;
    int accepted;
    logic r;
    cyc = 0;
    accepted = 0;
    while (exp_q.size() > 0 && accepted != stop_after) begin
      if (cyc > 100) begin
        check("drain_timeout", accepted, BLK_LEN);
        exp_q.delete();
        break;
      end
      @(negedge clk);
      in_valid = junk_in;
      llr = DATA_W'($urandom_range(1023));
      check("out_valid_drain", out_valid, 1);
      check("in_ready_drain", in_ready, 0);
      check("blk_done_drain", blk_done, 0);
      r = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
      out_ready = r;
      if (r) begin
        check("ext_order", ext, exp_q.pop_front());
        accepted++;
      end else begin
        check("ext_hold", ext, exp_q[0]);
      end
      cyc++;
    end
  endtask

  task automatic check_done();
    @(negedge clk);
    out_ready = 1'b0;
    check("blk_done_pulse", blk_done, 1);
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    llr = '0; sys = '0; apr = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_ext", ext, 0);
    check("rst_blk_done", blk_done, 0);
    rst = 1'b0;

    // Interleave order: expect 0,3,6,2,5,1,4
    for (int k = 0; k < BLK_LEN; k++) begin
      blk_llr[k] = k; blk_sys[k] = 0; blk_apr[k] = 0;
    end
    send_block(1'b0, 1'b0, 1'b0);
    drain(0, 1'b0, -1);
    check_done();
    in_valid = 1'b0;

    // De-interleave round trip: expect 0..6
    blk_llr = '{0, 3, 6, 2, 5, 1, 4};
    send_block(1'b1, 1'b0, 1'b0);
    drain(0, 1'b0, -1);
    check_done();
    in_valid = 1'b0;

    // Saturation/subtraction with backpressure and ignored input during DRAIN
    blk_llr = '{300, -300, 20, -64, 64, -512, 511};
    blk_sys = '{-10, 10, 5, 0, 0, 63, -64};
    blk_apr = '{0, 10, -3, 0, 0, 63, -64};
    send_block(1'b0, 1'b0, 1'b0);
    drain(1, 1'b1, -1);
    for (int k = 0; k < BLK_LEN; k++) begin
      blk_llr[k] = int'($urandom_range(1023)) - 512;
      blk_sys[k] = int'($urandom_range(127)) - 64;
      blk_apr[k] = int'($urandom_range(127)) - 64;
    end
    check_done();

    // Back-to-back: accepts begin in the blk_done cycle; mid-block mode flip ignored
    send_block(1'b1, 1'b1, 1'b1);
    drain(0, 1'b1, -1);
    for (int k = 0; k < BLK_LEN; k++) begin
      blk_llr[k] = int'($urandom_range(1023)) - 512;
      blk_sys[k] = int'($urandom_range(127)) - 64;
      blk_apr[k] = int'($urandom_range(127)) - 64;
    end
    check_done();
    send_block(1'b0, 1'b1, 1'b1);
    drain(1, 1'b0, -1);
    check_done();
    in_valid = 1'b0;

    // Reset after three outputs discards the block
    send_block(1'b1, 1'b0, 1'b0);
    drain(0, 1'b0, 3);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_blk_done", blk_done, 0);
    check("rst_mid_ext", ext, 0);
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_no_done", blk_done, 0);

    for (int k = 0; k < BLK_LEN; k++) begin
      blk_llr[k] = k * 5 - 10; blk_sys[k] = 0; blk_apr[k] = 0;
    end
    send_block(1'b0, 1'b0, 1'b0);
    drain(0, 1'b0, -1);
    check_done();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
